// File: rtl/ssd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ssd_pkg                                                           |
// | Desc   : Shared FSM state type and seven-segment codes for ssd_scan_ctrl.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } ssd_state_t;

    // Segment order is [6:0] = g..a, active low.
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ssd_scan_ctrl_if                                                  |
// | Desc   : Core-side value/handshake and board-side anode/segment bundle.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface ssd_scan_ctrl_if #(
    parameter int NUM_W  = 13,
    parameter int DIGITS = 8
);
    logic [NUM_W-1:0]  num;
    logic              load;
    logic              busy;
    logic              done;
    logic              ovf;
    logic [DIGITS-1:0] Anode;
    logic [6:0]        LED_out;

    modport master (output num, load, input  busy, done, ovf, Anode, LED_out);
    modport slave  (input  num, load, output busy, done, ovf, Anode, LED_out);
endinterface
`default_nettype wire

// File: rtl/ssd_bin2bcd.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ssd_bin2bcd                                                       |
// | Desc   : Serial double-dabble converter, one bit per clock after start.    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ssd_bin2bcd #(
    parameter int NUM_W = 13,
    parameter int BCD_W = 36
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             start,
    input  wire logic [NUM_W-1:0] bin,
    output logic                  busy,
    output logic                  last,
    output logic [BCD_W-1:0]      bcd
);
    localparam int BIT_W = $clog2(NUM_W + 1);

    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [NUM_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BCD_W-1:0] bcd_adj;

    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < BCD_W / 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end

        bit_cnt_d = bit_cnt_q;
        bin_d     = bin_q;
        bcd_d     = bcd_q;
        if (start) begin
            bit_cnt_d = BIT_W'(NUM_W);
            bin_d     = bin;
            bcd_d     = '0;
        end else if (bit_cnt_q != '0) begin
            {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
            bit_cnt_d      = bit_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt_q <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            bin_q     <= bin_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = (bit_cnt_q != '0);
    assign last = (bit_cnt_q == BIT_W'(1));
    assign bcd  = bcd_q;
endmodule
`default_nettype wire

// File: rtl/ssd_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ssd_scan_ctrl                                                     |
// | Desc   : Multiplexed 7-seg controller: BCD conversion, blanking, scanning. |
// |          Define SSD_SIGNED_EN to treat num as two's complement.            |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int NUM_W       = 13,
    parameter int DIGITS      = 8,
    parameter int REFRESH_DIV = 100000
) (
    input wire logic      clk,
    input wire logic      reset,
    ssd_scan_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int BCD_W = 4 * (DIGITS + 1);

    ssd_state_t state_q;
    logic       busy_q, done_q;
    logic       conv_start, conv_busy, conv_last;
    logic [NUM_W-1:0] mag;
    logic [BCD_W-1:0] conv_bcd;

    logic [DIGITS-1:0][6:0] seg_q, seg_d;
    logic [DIGITS-1:0]      lit_q, lit_d;
    logic                   ovf_q, ovf_d, ovf_calc;
    int                     msd;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic [6:0]        led_q, led_d;

    assign conv_start = (state_q == ST_IDLE) && bus.load;

`ifdef SSD_SIGNED_EN
    logic neg_q, neg_d;
    // Negation in NUM_W bits keeps the most negative value exact as unsigned.
    assign mag   = bus.num[NUM_W-1] ? (~bus.num + 1'b1) : bus.num;
    assign neg_d = conv_start ? bus.num[NUM_W-1] : neg_q;
    always_ff @(posedge clk) begin
        if (!reset) neg_q <= 1'b0;
        else        neg_q <= neg_d;
    end
`else
    assign mag = bus.num;
`endif

    ssd_bin2bcd #(.NUM_W(NUM_W), .BCD_W(BCD_W)) u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (mag),
        .busy  (conv_busy),
        .last  (conv_last),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.load) begin
                        state_q <= ST_CONVERT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (conv_last || !conv_busy) state_q <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (conv_bcd[4*i +: 4] != 4'd0) msd = i;
        end
        ovf_calc = (conv_bcd[BCD_W-1 -: 4] != 4'd0);
`ifdef SSD_SIGNED_EN
        if (neg_q && (msd + 1 >= DIGITS)) ovf_calc = 1'b1;
`endif

        seg_d = seg_q;
        lit_d = lit_q;
        ovf_d = ovf_q;
        if (state_q == ST_COMMIT) begin
            ovf_d = ovf_calc;
            for (int i = 0; i < DIGITS; i++) begin
                if (ovf_calc) begin
                    seg_d[i] = SEG_MINUS;
                    lit_d[i] = 1'b1;
                end else if (i <= msd) begin
                    seg_d[i] = seg_decode(conv_bcd[4*i +: 4]);
                    lit_d[i] = 1'b1;
                end
`ifdef SSD_SIGNED_EN
                else if (neg_q && (i == msd + 1)) begin
                    seg_d[i] = SEG_MINUS;
                    lit_d[i] = 1'b1;
                end
`endif
                else begin
                    seg_d[i] = SEG_BLANK;
                    lit_d[i] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end
        // A blanked digit keeps every anode off while its slot is scanned.
        anode_d = '1;
        if (lit_q[idx_q]) anode_d[idx_q] = 1'b0;
        led_d = seg_q[idx_q];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            seg_q   <= {DIGITS{SEG_ZERO}};
            lit_q   <= DIGITS'(1);
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            anode_q <= ~DIGITS'(1);
            led_q   <= SEG_ZERO;
        end else begin
            seg_q   <= seg_d;
            lit_q   <= lit_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            anode_q <= anode_d;
            led_q   <= led_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.ovf     = ovf_q;
    assign bus.Anode   = anode_q;
    assign bus.LED_out = led_q;
endmodule
`default_nettype wire
